wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the register file's single write port (rd_addr/rd_data) between NUM_REQ writeback requesters, e.g. ALU, load unit and multicycle divider.
- Grants one write per cycle, round-robin, through a registered output stage that drives the register file directly.
- Keeps a per-register busy scoreboard. Issue logic marks a destination register busy, and the matching writeback clears it.
- Issue logic uses the ra/rb busy flags to stall on RAW hazards.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- NUM_REGS, 32, number of architectural registers; must equal 2**$bits(regaddr_t).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- req_valid, input, NUM_REQ, requester i has a write pending.
- req_addr, input, NUM_REQ x regaddr_t, destination register per requester.
- req_data, input, NUM_REQ x u32_t, write data per requester.
- req_ready, output, NUM_REQ, requester i accepted this cycle (one-hot or zero).
- issue_valid, input, 1, an instruction with a destination register issues this cycle.
- issue_rd, input, regaddr_t, destination register of the issuing instruction.
- ra_query, input, regaddr_t, source register A to check.
- rb_query, input, regaddr_t, source register B to check.
- ra_busy, output, 1, ra_query has a write outstanding.
- rb_busy, output, 1, rb_query has a write outstanding.
- rd_addr, output, regaddr_t, to the register file write port.
- rd_data, output, u32_t, to the register file write port.

Behaviour:
- Reset: synchronous on rst_n low at posedge clk.
  - busy[] clears to 0, rd_addr to 0, rd_data to 0, round-robin pointer to 0.
  - While rst_n is low, req_ready is forced to 0 and issue_valid is ignored.
  - Reset mid-operation discards any write accepted in the same cycle.
- Idle encoding: the register file write port has no enable. The block therefore drives rd_addr=0 whenever no write is in the output stage; r0 writes are dropped by the register file.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first valid index g gets req_ready[g]=1; all other ready bits are 0.
  - If no request is valid, all ready bits are 0.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - The requester holds valid/addr/data stable until ready.
  - Valid may drop only after the transfer.
  - Ready depends on valid (no combinational loop is allowed on the requester side).
- Pointer: after a transfer by index g, ptr becomes (g+1) mod NUM_REQ. Without a transfer, ptr holds.
- Output stage:
  - At the accepting edge E1, rd_addr/rd_data load req_addr[g]/req_data[g].
  - With no transfer at E1, rd_addr loads 0 and rd_data holds.
  - The register file commits the write at the next edge E2, so latency from acceptance to data visible on regfile reads is 2 edges.
  - Throughput is 1 write per cycle.
- Scoreboard clear: at E2 (the edge the register file writes), busy[rd_addr] clears when rd_addr!=0. Busy and regfile contents therefore change together.
- Scoreboard set: at any edge with issue_valid=1 and issue_rd!=0, busy[issue_rd] sets.
- Set and clear on the same register at the same edge: set wins, because the new producer supersedes the old one.
- Register 0: issue_rd=0 is ignored and busy[0] is always 0.
- Writeback to a non-busy register is legal. It is written and busy stays 0.
- Busy query: ra_busy=busy[ra_query] and rb_busy=busy[rb_query], combinational from the registered busy[]. No bypass from the same-cycle issue or clear.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ cycles.

Decomposition:
- Types u32_t and regaddr_t come from the existing types package.
- Add typedef wb_req_t {regaddr_t addr; u32_t data;} to types.
- Add constant REG_ZERO='0 to types.
- One sub-module, rr_arbiter(NUM_REQ): valid vector in, one-hot grant out, pointer update on an accept input. It is reusable by future memory-port arbitration.

Test Plan:
1. Reset, then ra_query=5 and rb_query=0 → ra_busy=0, rb_busy=0, rd_addr=0, req_ready=000.
2. issue_rd=7, then req_valid[1]=1 with addr 7, data 0xDEADBEEF → req_ready=010 that cycle; rd_addr=7/rd_data=0xDEADBEEF after E1; busy[7] clears at E2; regfile r7 reads 0xDEADBEEF after E2.
3. All three requesters valid for 6 cycles from ptr=0 → grant order 0,1,2,0,1,2; each ready is asserted one cycle at a time.
4. Same edge: issue_rd=9 while the output stage holds rd_addr=9 → busy[9]=1 after the edge (set wins); r9 is still written.
5. issue_rd=0, and a writeback to r0 with data 0x1234 → busy[0] stays 0 and r0 reads 0.
6. Requester 2 accepted, then rst_n low for 1 cycle at E1 → rd_addr=0, busy all 0, ptr=0; no write reaches the regfile.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file writeback path: register addresses,
// data words and the writeback request record.
package wb_arbiter_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [4:0]  regaddr_t;

    typedef struct packed {
        regaddr_t addr;
        u32_t     data;
    } wb_req_t;

    localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the requesters, issue logic and the arbiter that
// owns the register file write port.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic     [NUM_REQ-1:0] req_valid;
    regaddr_t [NUM_REQ-1:0] req_addr;
    u32_t     [NUM_REQ-1:0] req_data;
    logic     [NUM_REQ-1:0] req_ready;

    logic     issue_valid;
    regaddr_t issue_rd;
    regaddr_t ra_query;
    regaddr_t rb_query;
    logic     ra_busy;
    logic     rb_busy;

    regaddr_t rd_addr;
    u32_t     rd_data;

    modport master (
        output req_valid, req_addr, req_data, issue_valid, issue_rd, ra_query, rb_query,
        input  req_ready, ra_busy, rb_busy, rd_addr, rd_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, issue_valid, issue_rd, ra_query, rb_query,
        output req_ready, ra_busy, rb_busy, rd_addr, rd_data
    );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched from the pointer,
// pointer moves past the winner whenever the grant is accepted.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_W  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Wrap the search index without a modulo so any NUM_REQ works.
            idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (idx >= NUM_W) begin
                idx = idx - NUM_W;
            end
            if (!found && valid[idx[PTR_W-1:0]]) begin
                found                   = 1'b1;
                grant[idx[PTR_W-1:0]]   = 1'b1;
                grant_idx               = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && found) begin
            ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register file write port between writeback requesters and
// tracks outstanding destination writes for RAW hazard stalls.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int NUM_REGS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    wb_req_t             win;
    wb_req_t             out_q;
    wb_req_t             out_d;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (bus.req_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign bus.req_ready = rst_n ? grant : '0;
    assign accept        = |bus.req_ready;

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i]) begin
                win.addr = bus.req_addr[i];
                win.data = bus.req_data[i];
            end
        end
    end

    // With no winner the address returns to r0, which the register file drops.
    always_comb begin
        out_d.addr = REG_ZERO;
        out_d.data = out_q.data;
        if (accept) begin
            out_d = win;
        end
    end

    // Clear on the edge the register file commits; a same-edge issue wins.
    always_comb begin
        busy_d = busy_q;
        if (out_q.addr != REG_ZERO) begin
            busy_d[out_q.addr] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != REG_ZERO)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            busy_q <= '0;
        end else begin
            out_q  <= out_d;
            busy_q <= busy_d;
        end
    end

    assign bus.rd_addr = out_q.addr;
    assign bus.rd_data = out_q.data;
    assign bus.ra_busy = busy_q[bus.ra_query];
    assign bus.rb_busy = busy_q[bus.rb_query];

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed stimulus queues expected grants
// and register-file writes, a negedge monitor checks them as they appear.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NR = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_REQ(NR)) bus();

    wb_arbiter #(
        .NUM_REQ  (NR),
        .NUM_REGS (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int      total = 0;
    int      bad   = 0;
    int      exp_grant_q[$];
    wb_req_t exp_wr_q[$];
    u32_t    rf[32] = '{default: 32'h0};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = REG_ZERO;
    endtask

    task automatic applyStimulus(input logic [NR-1:0] v,
                                 input regaddr_t a0, input regaddr_t a1, input regaddr_t a2,
                                 input u32_t d0, input u32_t d1, input u32_t d2,
                                 input logic iv, input regaddr_t ird, input int cycles);
        bus.req_valid   = v;
        bus.req_addr    = {a2, a1, a0};
        bus.req_data    = {d2, d1, d0};
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Register file model: commits whatever the output stage presents.
    always @(posedge clk) begin
        if (bus.rd_addr != REG_ZERO) begin
            rf[bus.rd_addr] <= bus.rd_data;
        end
    end

    always @(negedge clk) begin
        if (bus.req_ready !== '0) begin
            if (exp_grant_q.size() == 0) begin
                checkOutput("unexpected_grant", 32'(bus.req_ready), 32'h0);
            end else begin
                int g;
                g = exp_grant_q.pop_front();
                checkOutput("grant", 32'(bus.req_ready), 32'h1 << g);
            end
        end
        if (bus.rd_addr !== REG_ZERO) begin
            if (exp_wr_q.size() == 0) begin
                checkOutput("unexpected_write", 32'(bus.rd_addr), 32'h0);
            end else begin
                wb_req_t w;
                w = exp_wr_q.pop_front();
                checkOutput("wr_addr", 32'(bus.rd_addr), 32'(w.addr));
                checkOutput("wr_data", bus.rd_data, w.data);
            end
        end
    end

    initial begin
        int busy_cnt;
        idle();
        bus.ra_query = 5'd5;
        bus.rb_query = 5'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        checkOutput("rst_ra_busy", 32'(bus.ra_busy), 32'h0);
        checkOutput("rst_rb_busy", 32'(bus.rb_busy), 32'h0);
        checkOutput("rst_rd_addr", 32'(bus.rd_addr), 32'h0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);

        // Issue r7, then requester 1 writes it back
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd7, 1);
        idle();
        bus.ra_query = 5'd7;
        #1;
        checkOutput("r7_busy_after_issue", 32'(bus.ra_busy), 32'h1);
        exp_grant_q.push_back(1);
        exp_wr_q.push_back('{addr: 5'd7, data: 32'hDEADBEEF});
        applyStimulus(3'b010, 0, 5'd7, 0, 0, 32'hDEADBEEF, 0, 1'b0, 0, 1);
        idle();
        checkOutput("e1_rd_addr", 32'(bus.rd_addr), 32'd7);
        checkOutput("e1_rd_data", bus.rd_data, 32'hDEADBEEF);
        checkOutput("e1_r7_still_busy", 32'(bus.ra_busy), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("e2_r7_cleared", 32'(bus.ra_busy), 32'h0);
        checkOutput("e2_rf_r7", rf[7], 32'hDEADBEEF);
        checkOutput("e2_rd_addr_idle", 32'(bus.rd_addr), 32'h0);

        // Same-edge set and clear on r9 (pointer is 2, so requester 0 wins)
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd9, 1);
        exp_grant_q.push_back(0);
        exp_wr_q.push_back('{addr: 5'd9, data: 32'h00000099});
        applyStimulus(3'b001, 5'd9, 0, 0, 32'h99, 0, 0, 1'b0, 0, 1);
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd9, 1);
        idle();
        bus.ra_query = 5'd9;
        #1;
        checkOutput("r9_set_wins", 32'(bus.ra_busy), 32'h1);
        checkOutput("rf_r9", rf[9], 32'h99);

        // Register zero: issue and writeback are both dropped (pointer is 1)
        exp_grant_q.push_back(0);
        applyStimulus(3'b001, 5'd0, 0, 0, 32'h1234, 0, 0, 1'b1, 5'd0, 1);
        idle();
        bus.ra_query = 5'd0;
        #1;
        checkOutput("r0_busy", 32'(bus.ra_busy), 32'h0);
        checkOutput("r0_rd_addr", 32'(bus.rd_addr), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rf_r0", rf[0], 32'h0);

        // Reset in the cycle requester 2 is valid
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 5'd3, 1);
        idle();
        bus.ra_query = 5'd3;
        #1;
        checkOutput("r3_busy_before_rst", 32'(bus.ra_busy), 32'h1);
        rst_n = 1'b0;
        bus.req_valid = 3'b100;
        bus.req_addr  = {5'd5, 5'd0, 5'd0};
        bus.req_data  = {32'h55, 32'h0, 32'h0};
        #1;
        checkOutput("rst_ready_forced", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        checkOutput("rst_mid_rd_addr", 32'(bus.rd_addr), 32'h0);
        busy_cnt = 0;
        for (int r = 0; r < 32; r++) begin
            bus.ra_query = regaddr_t'(r);
            #1;
            busy_cnt += int'(bus.ra_busy);
        end
        checkOutput("rst_busy_all_clear", 32'(busy_cnt), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rf_r5_untouched", rf[5], 32'h0);

        // All requesters valid from pointer 0
        for (int k = 0; k < 6; k++) begin
            exp_grant_q.push_back(k % NR);
            exp_wr_q.push_back('{addr: regaddr_t'(10 + (k % NR)), data: 32'h1000 + 32'(k % NR)});
        end
        applyStimulus(3'b111, 5'd10, 5'd11, 5'd12, 32'h1000, 32'h1001, 32'h1002, 1'b0, 0, 6);
        idle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rf_r10", rf[10], 32'h1000);
        checkOutput("rf_r12", rf[12], 32'h1002);
        checkOutput("grant_q_drained", 32'(exp_grant_q.size()), 32'h0);
        checkOutput("wr_q_drained", 32'(exp_wr_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
